// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU command front end.
//   seq_state_t : sequencer FSM states
//   alu_cmd_t   : one buffered command {sel, op, a, b}
//   is_illegal  : true for commands the ALU must never see
package alu_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StCapture = 2'd2,
    StClear   = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic       sel;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } alu_cmd_t;

  localparam logic       SelGroupA = 1'b0;
  localparam logic       SelGroupB = 1'b1;

  localparam logic [1:0] Op00 = 2'b00;
  localparam logic [1:0] Op01 = 2'b01;
  localparam logic [1:0] Op10 = 2'b10;
  localparam logic [1:0] Op11 = 2'b11;

  // Operand/opcode combinations the ALU treats as illegal input.
  function automatic logic is_illegal(input alu_cmd_t cmd);
    logic ill;
    ill = 1'b0;
    if (cmd.sel == SelGroupA) begin
      case (cmd.op)
        Op00:    ill = (cmd.b == 8'h00);
        Op01:    ill = (cmd.a == 8'hFF) || (cmd.b == 8'h03);
        default: ill = 1'b0;
      endcase
    end else begin
      case (cmd.op)
        Op01:    ill = (cmd.b == 8'h03);
        Op10:    ill = (cmd.a == 8'hF5);
        default: ill = 1'b0;
      endcase
    end
    return ill;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of alu_cmd_t.
//   alu_clk, alu_rst : clock, async active-high reset
//   push, wdata      : write a command (ignored while full)
//   pop, rdata       : rdata is the head; pop removes it (ignored while empty)
//   full, empty      : registered occupancy flags
// DEPTH must be a power of 2 and at least 2. Pointers carry one extra wrap bit
// so full and empty can be told apart when the address bits match.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     alu_clk,
  input  logic     alu_rst,
  input  logic     push,
  input  alu_cmd_t wdata,
  input  logic     pop,
  output alu_cmd_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  alu_cmd_t      mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push_en, pop_en;

  assign push_en = push & ~full_q;
  assign pop_en  = pop & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_en};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_en};
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
  end

  always_ff @(posedge alu_clk or posedge alu_rst) begin
    if (alu_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge alu_clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front end for the ALU: buffers valid/ready commands, drops illegal
// ones at entry, issues each remaining command as a single enable cycle,
// captures the result and clears any raised ALU interrupt.
//   cmd_*         : command handshake in, cmd_reject pulses on a dropped command
//   alu_*  (out)  : every ALU input except clock/reset, all registered
//   alu_out/irq   : ALU result and interrupt
//   res_*         : captured result, res_valid pulses once per command
//   irq_count     : saturating count of serviced interrupts
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned IRQ_CNT_W = 8
) (
  input  logic                 alu_clk,
  input  logic                 alu_rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_sel,
  input  logic [1:0]           cmd_op,
  input  logic [7:0]           cmd_a,
  input  logic [7:0]           cmd_b,
  output logic                 cmd_reject,
  output logic                 alu_enable,
  output logic                 alu_enable_a,
  output logic                 alu_enable_b,
  output logic [1:0]           alu_op_a,
  output logic [1:0]           alu_op_b,
  output logic [7:0]           alu_in_a,
  output logic [7:0]           alu_in_b,
  output logic                 alu_irq_clr,
  input  logic [7:0]           alu_out,
  input  logic                 alu_irq,
  output logic                 res_valid,
  output logic [7:0]           res_data,
  output logic                 res_irq,
  output logic [IRQ_CNT_W-1:0] irq_count
);

  alu_cmd_t   cmd_in, head;
  logic       fifo_full, fifo_empty;
  logic       take, illegal, push, pop;

  seq_state_t           state_q, state_d;
  logic                 en_q, en_d;
  logic                 en_a_q, en_a_d;
  logic                 en_b_q, en_b_d;
  logic [1:0]           op_a_q, op_a_d;
  logic [1:0]           op_b_q, op_b_d;
  logic [7:0]           in_a_q, in_a_d;
  logic [7:0]           in_b_q, in_b_d;
  logic                 irq_clr_q, irq_clr_d;
  logic                 res_valid_q, res_valid_d;
  logic [7:0]           res_data_q, res_data_d;
  logic                 res_irq_q, res_irq_d;
  logic [IRQ_CNT_W-1:0] irq_cnt_q, irq_cnt_d;
  logic                 reject_q;

  assign cmd_in  = '{sel: cmd_sel, op: cmd_op, a: cmd_a, b: cmd_b};
  assign take    = cmd_valid & ~fifo_full;
  assign illegal = is_illegal(cmd_in);
  // Illegal commands complete the handshake but are never stored.
  assign push    = take & ~illegal;
  assign pop     = (state_q == StIdle) & ~fifo_empty;

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .alu_clk (alu_clk),
    .alu_rst (alu_rst),
    .push    (push),
    .wdata   (cmd_in),
    .pop     (pop),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    en_d        = 1'b0;
    en_a_d      = 1'b0;
    en_b_d      = 1'b0;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    in_a_d      = in_a_q;
    in_b_d      = in_b_q;
    irq_clr_d   = 1'b0;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_irq_d   = res_irq_q;
    irq_cnt_d   = irq_cnt_q;
    unique case (state_q)
      StIdle: begin
        // Enables are loaded here so they are high for exactly the ISSUE cycle.
        if (!fifo_empty) begin
          state_d = StIssue;
          en_d    = 1'b1;
          en_a_d  = ~head.sel;
          en_b_d  = head.sel;
          in_a_d  = head.a;
          in_b_d  = head.b;
          if (head.sel == SelGroupB) begin
            op_b_d = head.op;
          end else begin
            op_a_d = head.op;
          end
        end
      end
      StIssue: begin
        state_d = StCapture;
      end
      StCapture: begin
        res_data_d  = alu_out;
        res_irq_d   = alu_irq;
        res_valid_d = 1'b1;
        if (alu_irq) begin
          state_d   = StClear;
          irq_clr_d = 1'b1;
          if (irq_cnt_q != {IRQ_CNT_W{1'b1}}) begin
            irq_cnt_d = irq_cnt_q + {{(IRQ_CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = StIdle;
        end
      end
      StClear: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge alu_clk or posedge alu_rst) begin
    if (alu_rst) begin
      state_q     <= StIdle;
      en_q        <= 1'b0;
      en_a_q      <= 1'b0;
      en_b_q      <= 1'b0;
      op_a_q      <= 2'b00;
      op_b_q      <= 2'b00;
      in_a_q      <= 8'h00;
      in_b_q      <= 8'h00;
      irq_clr_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'h00;
      res_irq_q   <= 1'b0;
      irq_cnt_q   <= '0;
      reject_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      en_a_q      <= en_a_d;
      en_b_q      <= en_b_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      in_a_q      <= in_a_d;
      in_b_q      <= in_b_d;
      irq_clr_q   <= irq_clr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_irq_q   <= res_irq_d;
      irq_cnt_q   <= irq_cnt_d;
      reject_q    <= take & illegal;
    end
  end

  assign cmd_ready    = ~fifo_full;
  assign cmd_reject   = reject_q;
  assign alu_enable   = en_q;
  assign alu_enable_a = en_a_q;
  assign alu_enable_b = en_b_q;
  assign alu_op_a     = op_a_q;
  assign alu_op_b     = op_b_q;
  assign alu_in_a     = in_a_q;
  assign alu_in_b     = in_b_q;
  assign alu_irq_clr  = irq_clr_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_irq      = res_irq_q;
  assign irq_count    = irq_cnt_q;

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command front end for the ALU. It accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO. Commands that would violate the ALU's illegal-input rules are dropped at entry. Each remaining command is issued to the ALU as a single enable cycle, the ALU result is captured, and any raised ALU interrupt is serviced with a one-cycle `alu_irq_clr` pulse. It sits directly upstream of the ALU and owns every ALU input except clock and reset.

## Interface
- `DEPTH`, default 4: command FIFO depth; must be a power of 2 and at least 2.
- `IRQ_CNT_W`, default 8: width of the interrupt event counter.

Ports, listed as name, direction, width, meaning:
- `alu_clk` input 1: the single clock.
- `alu_rst` input 1: asynchronous, active-high reset. The ALU itself is reset from the same source, inverted at the top level.
- `cmd_valid` input 1: a command is presented.
- `cmd_ready` output 1: the FIFO can accept a command.
- `cmd_sel` input 1: operation group; 0 selects group A, 1 selects group B.
- `cmd_op` input 2: opcode within the selected group.
- `cmd_a`, `cmd_b` input 8 each: operands.
- `cmd_reject` output 1: one-cycle pulse when an accepted command is dropped as illegal.
- `alu_enable`, `alu_enable_a`, `alu_enable_b` output 1 each: ALU enables.
- `alu_op_a`, `alu_op_b` output 2 each: ALU opcodes.
- `alu_in_a`, `alu_in_b` output 8 each: ALU operands.
- `alu_irq_clr` output 1: ALU interrupt clear.
- `alu_out` input 8: ALU result.
- `alu_irq` input 1: ALU interrupt.
- `res_valid` output 1: one-cycle pulse marking a captured result.
- `res_data` output 8: captured result.
- `res_irq` output 1: interrupt flag captured with the result.
- `irq_count` output `IRQ_CNT_W`: saturating count of serviced interrupts.

## Operation
**Handshake**
- A transfer occurs when `cmd_valid` and `cmd_ready` are both high.
- `cmd_ready` = !full. It is registered and depends only on FIFO occupancy.
- The producer holds the command stable while `cmd_valid` is high and `cmd_ready` is low.

**Illegal-command filter** (applied at transfer)
- Group A, op 00: `cmd_b` == 00.
- Group A, op 01: `cmd_a` == FF, or `cmd_b` == 03.
- Group B, op 01: `cmd_b` == 03.
- Group B, op 10: `cmd_a` == F5.
- A matching command counts as accepted, is not stored, and pulses `cmd_reject` in the next cycle.

**FSM states:** IDLE, ISSUE, CAPTURE, CLEAR.
- IDLE: if the FIFO is not empty, pop the head into the operand registers and go to ISSUE.
- ISSUE: drive the ALU enables for exactly one cycle, then go to CAPTURE.
  - `alu_enable` = 1.
  - `alu_enable_a` = !sel and `alu_enable_b` = sel.
  - The opcode goes to `alu_op_a` or `alu_op_b` according to sel.
- CAPTURE: all enables are 0. At the end of the cycle:
  - `res_data` <= `alu_out`, `res_irq` <= `alu_irq`, `res_valid` <= 1.
  - Next state is CLEAR if `alu_irq` is high, otherwise IDLE.
- CLEAR: `alu_irq_clr` = 1 for one cycle, `irq_count` increments (saturating at all-ones), then go to IDLE.

**Output holding**
- `alu_in_a`, `alu_in_b` and the non-selected opcode hold their last values between commands.

**Boundary conditions**
- Push while full cannot happen, because `cmd_ready` is low.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- A push into an empty FIFO can be popped no earlier than the following cycle.
- An interrupt that was already pending is still serviced in CLEAR. The ALU never receives enable and clear in the same cycle.

## Timing
- All outputs are registered.
- Reset values:
  - `cmd_ready` = 1.
  - All other outputs = 0, including `irq_count` and `res_*`.
  - FIFO empty, state IDLE.
- Reset is asynchronous at any point, including mid-command. The in-flight command and all buffered commands are discarded, and no `res_valid` is produced for them.
- Latency, counted from the cycle in which the command is pushed:
  - Minimum 2 cycles to ISSUE.
  - `res_valid` 4 cycles after the push.
- Throughput: one command every 3 cycles without an interrupt, every 4 cycles with one.
- `res_valid` is high during the cycle that follows CAPTURE. When an interrupt is pending, that cycle coincides with the `alu_irq_clr` cycle.

## Structure
- Package `alu_pkg` holds:
  - the `seq_state_t` enum;
  - the `alu_cmd_t` packed struct: sel, op[1:0], a[7:0], b[7:0];
  - the opcode localparams;
  - the function `is_illegal(alu_cmd_t)`.
- Sub-module `alu_cmd_fifo`: parameterised synchronous FIFO of `alu_cmd_t`, with full/empty flags and pointers one bit wider than the address.
- The top level contains the filter, the FSM, the result registers and the counter.

## Test plan
- Group A, op 10, a=F0, b=08 → ISSUE with `alu_enable_a`=1; `res_data`=F8, `res_irq`=1; `alu_irq_clr` pulses once; `irq_count`=1.
- Group A, op 00, b=00 → `cmd_reject` pulses; no ISSUE, no `res_valid`. Then group A, op 00, a=3C, b=0F → `res_data`=0C, `res_irq`=0, `irq_count` unchanged.
- Push 8 legal commands back-to-back → `cmd_ready` falls once occupancy reaches 4. All 8 results arrive in order with no loss or duplication.
- Group B, op 11, a=0F, b=F0 → `alu_enable_b`=1, `alu_op_b`=11; `res_data`=FF, `res_irq`=1. Follow with group B, op 00, a=00, b=00 → `res_data`=FF, `res_irq`=0.
- Assert `alu_rst` during CAPTURE with 3 commands queued → all outputs return to reset values immediately. No `res_valid` appears after release; the FIFO is empty.
- Issue 257 interrupt-raising commands → `irq_count` saturates at FF.
